framebuffer_reader: RTL and testbench



---
 rtl/framebuffer_reader_pkg.sv | 40 ++++
 rtl/sync_fifo.sv | 79 +++++++
 rtl/framebuffer_reader.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_framebuffer_reader.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/framebuffer_reader_pkg.sv
// framebuffer_reader_pkg: definitions shared by the frame buffer reader and
// its FIFO. It holds the FSM state encoding, the CI command codes, the burst
// length limit, the FIFO entry width and the burst-size clamp.
package framebuffer_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_REQUEST_BUS = 3'd1,
    ST_INIT_BURST  = 3'd2,
    ST_WAIT_DATA   = 3'd3,
    ST_NEXT        = 3'd4,
    ST_FRAME_DONE  = 3'd5,
    ST_ERROR       = 3'd6
  } fb_state_e;

  typedef enum logic [2:0] {
    CI_RD_BASE   = 3'd0,
    CI_WR_BASE   = 3'd1,
    CI_WR_WPL    = 3'd2,
    CI_WR_LPF    = 3'd3,
    CI_WR_CTRL   = 3'd4,
    CI_RD_STATUS = 3'd5,
    CI_RD_COUNT  = 3'd6,
    CI_NOP       = 3'd7
  } ci_cmd_e;

  localparam int unsigned MAX_BURST = 16;
  // Each FIFO entry is {lastInFrame, lastInLine, data[31:0]}.
  localparam int unsigned FIFO_W    = 34;

  // The next burst is the smaller of MAX_BURST and the words still left in
  // the current line, so a burst never crosses a line boundary.
  function automatic logic [9:0] clamp_burst(input logic [8:0] wpl,
                                             input logic [8:0] word_idx);
    logic [9:0] rem;
    rem = {1'b0, wpl} - {1'b0, word_idx};
    return (rem > 10'(MAX_BURST)) ? 10'(MAX_BURST) : rem;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   flush               synchronous clear of every entry
//   push, push_data     write side; a push while full is dropped
//   pop                 read side; pop_data already shows the head entry
//   pop_data            head entry, driven to 0 while the FIFO is empty
//   full, empty         status flags
//   free_count          number of free slots
module sync_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty      = (count_q == '0);
  assign full       = (count_q == DEPTH_C);
  assign free_count = DEPTH_C - count_q;
  assign do_push    = push & ~full;
  assign do_pop     = pop & ~empty;
  // The gate keeps the stream data at 0 while nothing is queued.
  assign pop_data   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/framebuffer_reader.sv
// framebuffer_reader: burst-read DMA master. It fetches a frame of 32-bit
// words from the shared bus and delivers them on a valid/ready stream.
// Ports:
//   clock, reset                  system clock and asynchronous active-high reset
//   ciStart/ciCke/ciN/ciValueA/B  custom-instruction request; ciValueA[2:0] selects the command
//   ciResult, ciDone              CI read value and combinational done
//   requestBus, busGrant          bus arbitration
//   beginTransactionOut, endTransactionOut, addressDataOut,
//   byteEnablesOut, readNotWriteOut, burstSizeOut   registered burst framing
//   addressDataIn, dataValidIn, endTransactionIn, busErrorIn   slave responses
//   streamData/Valid/Ready, streamLastInLine/Frame             pixel stream out
module framebuffer_reader
  import framebuffer_reader_pkg::*;
#(
  parameter logic [7:0]  customInstructionId = 8'd0,
  parameter int unsigned fifoDepth           = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic        ciCke,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic [31:0] ciResult,
  output logic        ciDone,
  output logic        requestBus,
  input  logic        busGrant,
  output logic        beginTransactionOut,
  output logic        endTransactionOut,
  output logic [31:0] addressDataOut,
  output logic [3:0]  byteEnablesOut,
  output logic        readNotWriteOut,
  output logic [7:0]  burstSizeOut,
  input  logic [31:0] addressDataIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  input  logic        busErrorIn,
  output logic [31:0] streamData,
  output logic        streamValid,
  input  logic        streamReady,
  output logic        streamLastInLine,
  output logic        streamLastInFrame
);

  localparam int unsigned FAW = $clog2(fifoDepth);

  fb_state_e   state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [8:0]  wpl_q, wpl_d;
  logic [10:0] lpf_q, lpf_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        err_q, err_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  // Shadows of the geometry and base for the frame in flight.
  logic [31:0] base_sh_q, base_sh_d;
  logic [8:0]  wpl_sh_q, wpl_sh_d;
  logic [10:0] lpf_sh_q, lpf_sh_d;
  logic [31:0] addr_q, addr_d;
  logic [8:0]  word_q, word_d;
  logic [10:0] line_q, line_d;
  logic        req_q, req_d;
  logic        begin_q, begin_d;
  logic        end_q, end_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  be_q, be_d;
  logic        rnw_q, rnw_d;
  logic [7:0]  burst_q, burst_d;

  logic              ci_sel, busy, geom_ok, room_ok, last_line, last_frame, start_frame;
  ci_cmd_e           ci_cmd;
  logic [9:0]        burst_len;
  logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [FIFO_W-1:0] fifo_din, fifo_dout;
  logic [FAW:0]      fifo_free;
  logic              unused_ok;

  assign unused_ok = ^{ciValueA[31:3], fifo_full};

  assign ci_sel  = ciStart & ciCke & (ciN == customInstructionId);
  assign ciDone  = ci_sel;
  assign ci_cmd  = ci_cmd_e'(ciValueA[2:0]);
  assign busy    = (state_q != ST_IDLE) | ~fifo_empty;
  assign geom_ok = (wpl_q != '0) && (lpf_q != '0);

  assign burst_len  = clamp_burst(wpl_sh_q, word_q);
  assign room_ok    = (32'(fifo_free) >= 32'(burst_len));
  assign last_line  = (word_q == wpl_sh_q - 9'd1);
  assign last_frame = last_line && (line_q == lpf_sh_q - 11'd1);

  always_comb begin
    ciResult = '0;
    if (ci_sel) begin
      case (ci_cmd)
        CI_RD_BASE:   ciResult = base_q;
        CI_RD_STATUS: ciResult = {30'd0, err_q, busy};
        CI_RD_COUNT:  ciResult = {16'd0, frame_cnt_q};
        default:      ciResult = '0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    wpl_d       = wpl_q;
    lpf_d       = lpf_q;
    ctrl_d      = ctrl_q;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    base_sh_d   = base_sh_q;
    wpl_sh_d    = wpl_sh_q;
    lpf_sh_d    = lpf_sh_q;
    addr_d      = addr_q;
    word_d      = word_q;
    line_d      = line_q;
    req_d       = 1'b0;
    begin_d     = 1'b0;
    end_d       = 1'b0;
    bus_addr_d  = '0;
    be_d        = '0;
    rnw_d       = 1'b0;
    burst_d     = '0;
    fifo_push   = 1'b0;
    fifo_flush  = 1'b0;
    fifo_din    = '0;
    start_frame = 1'b0;

    // CI writes come first, so the FSM below can override control and the
    // error flag in the same cycle.
    if (ci_sel) begin
      case (ci_cmd)
        CI_WR_BASE:   base_d = {ciValueB[31:2], 2'b00};
        CI_WR_WPL:    wpl_d  = ciValueB[8:0];
        CI_WR_LPF:    lpf_d  = ciValueB[10:0];
        CI_WR_CTRL:   ctrl_d = ciValueB[1:0];
        CI_RD_STATUS: err_d  = 1'b0;
        default:      ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (ctrl_q != 2'b00) begin
          if (geom_ok) start_frame = 1'b1;
          else         ctrl_d      = 2'b00;
        end
      end
      ST_REQUEST_BUS: begin
        if (req_q && busGrant) state_d = ST_INIT_BURST;
        else                   req_d   = room_ok;
      end
      ST_INIT_BURST: begin
        begin_d    = 1'b1;
        bus_addr_d = addr_q;
        be_d       = 4'hF;
        rnw_d      = 1'b1;
        burst_d    = 8'(burst_len - 10'd1);
        state_d    = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (busErrorIn) begin
          state_d = ST_ERROR;
        end else begin
          if (dataValidIn) begin
            fifo_push = 1'b1;
            fifo_din  = {last_frame, last_line, addressDataIn};
            addr_d    = addr_q + 32'd4;
            if (last_line) begin
              word_d = '0;
              line_d = line_q + 11'd1;
            end else begin
              word_d = word_q + 9'd1;
            end
          end
          if (endTransactionIn) state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        // The line counter is already past the last line once the frame is done.
        state_d = (line_q == lpf_sh_q) ? ST_FRAME_DONE : ST_REQUEST_BUS;
      end
      ST_FRAME_DONE: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        if (ctrl_q[1] && geom_ok) begin
          start_frame = 1'b1;
        end else begin
          ctrl_d  = ctrl_q[1] ? 2'b00 : {ctrl_q[1], 1'b0};
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: begin
        end_d      = 1'b1;
        err_d      = 1'b1;
        fifo_flush = 1'b1;
        ctrl_d     = 2'b00;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_frame) begin
      base_sh_d = base_q;
      wpl_sh_d  = wpl_q;
      lpf_sh_d  = lpf_q;
      addr_d    = base_q;
      word_d    = '0;
      line_d    = '0;
      state_d   = ST_REQUEST_BUS;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      wpl_q       <= '0;
      lpf_q       <= '0;
      ctrl_q      <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      base_sh_q   <= '0;
      wpl_sh_q    <= '0;
      lpf_sh_q    <= '0;
      addr_q      <= '0;
      word_q      <= '0;
      line_q      <= '0;
      req_q       <= 1'b0;
      begin_q     <= 1'b0;
      end_q       <= 1'b0;
      bus_addr_q  <= '0;
      be_q        <= '0;
      rnw_q       <= 1'b0;
      burst_q     <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      wpl_q       <= wpl_d;
      lpf_q       <= lpf_d;
      ctrl_q      <= ctrl_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      base_sh_q   <= base_sh_d;
      wpl_sh_q    <= wpl_sh_d;
      lpf_sh_q    <= lpf_sh_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      line_q      <= line_d;
      req_q       <= req_d;
      begin_q     <= begin_d;
      end_q       <= end_d;
      bus_addr_q  <= bus_addr_d;
      be_q        <= be_d;
      rnw_q       <= rnw_d;
      burst_q     <= burst_d;
    end
  end

  assign requestBus          = req_q;
  assign beginTransactionOut = begin_q;
  assign endTransactionOut   = end_q;
  assign addressDataOut      = bus_addr_q;
  assign byteEnablesOut      = be_q;
  assign readNotWriteOut     = rnw_q;
  assign burstSizeOut        = burst_q;

  assign streamValid       = ~fifo_empty;
  assign fifo_pop          = streamValid & streamReady;
  assign streamData        = fifo_dout[31:0];
  assign streamLastInLine  = fifo_dout[32];
  assign streamLastInFrame = fifo_dout[33];

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (fifoDepth)
  ) u_fifo (
    .clk        (clock),
    .rst        (reset),
    .flush      (fifo_flush),
    .push       (fifo_push),
    .push_data  (fifo_din),
    .pop        (fifo_pop),
    .pop_data   (fifo_dout),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .free_count (fifo_free)
  );

endmodule

// File: tb/tb_framebuffer_reader.sv
`timescale 1ns/1ps
module tb_framebuffer_reader;

  logic        clock, reset;
  logic        ciStart, ciCke;
  logic [7:0]  ciN;
  logic [31:0] ciValueA, ciValueB, ciResult;
  logic        ciDone, requestBus, busGrant;
  logic        beginTransactionOut, endTransactionOut;
  logic [31:0] addressDataOut, addressDataIn, streamData;
  logic [3:0]  byteEnablesOut;
  logic        readNotWriteOut;
  logic [7:0]  burstSizeOut;
  logic        dataValidIn, endTransactionIn, busErrorIn;
  logic        streamValid, streamReady, streamLastInLine, streamLastInFrame;

  framebuffer_reader #(.customInstructionId(8'd0), .fifoDepth(32)) dut (
    .clock(clock), .reset(reset),
    .ciStart(ciStart), .ciCke(ciCke), .ciN(ciN), .ciValueA(ciValueA), .ciValueB(ciValueB),
    .ciResult(ciResult), .ciDone(ciDone),
    .requestBus(requestBus), .busGrant(busGrant),
    .beginTransactionOut(beginTransactionOut), .endTransactionOut(endTransactionOut),
    .addressDataOut(addressDataOut), .byteEnablesOut(byteEnablesOut),
    .readNotWriteOut(readNotWriteOut), .burstSizeOut(burstSizeOut),
    .addressDataIn(addressDataIn), .dataValidIn(dataValidIn),
    .endTransactionIn(endTransactionIn), .busErrorIn(busErrorIn),
    .streamData(streamData), .streamValid(streamValid), .streamReady(streamReady),
    .streamLastInLine(streamLastInLine), .streamLastInFrame(streamLastInFrame)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] salt;

  // Observed bursts and stream words; expected counterparts from the model.
  logic [31:0] bq_addr[$];
  int          bq_len[$];
  logic [33:0] got[$];
  logic [33:0] exp_q[$];
  logic [31:0] eb_addr[$];
  int          eb_len[$];

  int ready_mode  = 1;   // 0 hold low, 1 random, 2 always high
  int err_burst   = -1;  // index of the burst that answers with busErrorIn
  int err_after   = 2;   // words delivered before that error
  int end_pulses  = 0;
  int req_cycles  = 0;
  int framing_bad = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ salt;
  endfunction

  // Bus slave: grants requests, answers each burst with its words after
  // random gaps, then endTransactionIn; can inject an error on one burst.
  int          s_left = 0;
  int          s_sent = 0;
  int          s_idx  = 0;
  logic        s_end_pending = 1'b0;
  logic [31:0] s_addr = '0;
  always @(negedge clock) begin
    dataValidIn      = 1'b0;
    endTransactionIn = 1'b0;
    busErrorIn       = 1'b0;
    addressDataIn    = '0;
    busGrant         = 1'b0;
    if (reset) begin
      s_left        = 0;
      s_end_pending = 1'b0;
    end else begin
      busGrant = requestBus && ($urandom_range(0, 2) == 0);
      if (requestBus) req_cycles++;
      if (endTransactionOut) end_pulses++;
      if (beginTransactionOut) begin
        if (byteEnablesOut !== 4'hF || readNotWriteOut !== 1'b1) framing_bad++;
        bq_addr.push_back(addressDataOut);
        bq_len.push_back(int'(burstSizeOut) + 1);
        s_idx  = bq_addr.size() - 1;
        s_left = int'(burstSizeOut) + 1;
        s_addr = addressDataOut;
        s_sent = 0;
      end else begin
        if ((addressDataOut | 32'(byteEnablesOut) | 32'(burstSizeOut)) != 0 || readNotWriteOut)
          framing_bad++;
        if (s_left > 0) begin
          if (s_idx == err_burst && s_sent == err_after) begin
            busErrorIn = 1'b1;
            s_left     = 0;
          end else if ($urandom_range(0, 3) != 0) begin
            dataValidIn   = 1'b1;
            addressDataIn = mem_word(s_addr);
            s_addr        = s_addr + 32'd4;
            s_sent++;
            s_left--;
            if (s_left == 0) s_end_pending = 1'b1;
          end
        end else if (s_end_pending) begin
          endTransactionIn = 1'b1;
          s_end_pending    = 1'b0;
        end
      end
    end
  end

  // Consumer: drives streamReady and records every word it accepts.
  logic ready_next;
  always @(negedge clock) begin
    case (ready_mode)
      0:       ready_next = 1'b0;
      1:       ready_next = ($urandom_range(0, 2) != 0);
      default: ready_next = 1'b1;
    endcase
    streamReady = ready_next;
    if (!reset && streamValid && ready_next)
      got.push_back({streamLastInFrame, streamLastInLine, streamData});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic ci_write(input logic [2:0] cmd, input logic [31:0] val);
    ciStart = 1'b1; ciCke = 1'b1; ciN = 8'd0; ciValueA = {29'd0, cmd}; ciValueB = val;
    @(negedge clock);
    ciStart = 1'b0; ciCke = 1'b0; ciValueA = '0; ciValueB = '0;
  endtask

  task automatic ci_read(input logic [2:0] cmd, output logic [31:0] val, output logic done);
    ciStart = 1'b1; ciCke = 1'b1; ciN = 8'd0; ciValueA = {29'd0, cmd}; ciValueB = '0;
    #1;
    val  = ciResult;
    done = ciDone;
    @(negedge clock);
    ciStart = 1'b0; ciCke = 1'b0; ciValueA = '0;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] v;
    logic d;
    v = 32'd1;
    for (int i = 0; i < 3000; i++) begin
      ci_read(3'd5, v, d);
      if (v[0] == 1'b0) break;
    end
    check({tag, "_idle"}, v[0], 1'b0);
  endtask

  task automatic wait_bursts(input string tag, input int n);
    int i;
    for (i = 0; i < 2000; i++) begin
      if (bq_addr.size() >= n) break;
      tick(1);
    end
    check({tag, "_burst_wait"}, 64'(bq_addr.size() >= n), 64'd1);
  endtask

  task automatic clear_all();
    got.delete(); exp_q.delete(); bq_addr.delete(); bq_len.delete();
    eb_addr.delete(); eb_len.delete();
  endtask

  // Reference frame: row-major words at base + 4*index, line tags on each
  // line's last word, bursts of at most 16 that restart at every line.
  task automatic build_expected(input logic [31:0] base, input int wpl, input int lpf);
    logic [31:0] a;
    logic lil, lif;
    for (int l = 0; l < lpf; l++) begin
      for (int w = 0; w < wpl; w++) begin
        a   = base + 32'(4 * (l * wpl + w));
        lil = (w == wpl - 1);
        lif = lil && (l == lpf - 1);
        exp_q.push_back({lif, lil, mem_word(a)});
      end
      for (int w = 0; w < wpl; w += 16) begin
        eb_addr.push_back(base + 32'(4 * (l * wpl + w)));
        eb_len.push_back((wpl - w) > 16 ? 16 : (wpl - w));
      end
    end
  endtask

  task automatic compare_run(input string tag);
    int n;
    check({tag, "_word_count"}, 64'(got.size()), 64'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_word%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
    check({tag, "_burst_count"}, 64'(bq_addr.size()), 64'(eb_addr.size()));
    n = (bq_addr.size() < eb_addr.size()) ? bq_addr.size() : eb_addr.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_burst%0d_addr", tag, i), 64'(bq_addr[i]), 64'(eb_addr[i]));
      check($sformatf("%s_burst%0d_len", tag, i), 64'(bq_len[i]), 64'(eb_len[i]));
    end
  endtask

  logic [31:0] rv;
  logic        rd;
  int          nb;

  initial begin
    salt    = $urandom;
    reset   = 1'b1;
    ciStart = 1'b0; ciCke = 1'b0; ciN = 8'd0; ciValueA = '0; ciValueB = '0;
    busGrant = 1'b0; addressDataIn = '0; dataValidIn = 1'b0;
    endTransactionIn = 1'b0; busErrorIn = 1'b0; streamReady = 1'b0;
    tick(3);

    // Reset state
    check("rst_bus_outs", {requestBus, beginTransactionOut, endTransactionOut, addressDataOut,
          byteEnablesOut, readNotWriteOut, burstSizeOut}, 64'd0);
    check("rst_stream_outs", {streamValid, streamLastInLine, streamLastInFrame, streamData}, 64'd0);
    check("rst_ci_outs", {ciDone, ciResult}, 64'd0);
    reset = 1'b0;
    tick(2);
    ci_read(3'd5, rv, rd);
    check("rst_status", rv, 32'd0);
    check("ci_done_selected", rd, 1'b1);
    ci_read(3'd6, rv, rd);
    check("rst_frame_count", rv, 32'd0);
    ci_read(3'd0, rv, rd);
    check("rst_base", rv, 32'd0);

    // A CI number other than ours is not answered
    ciStart = 1'b1; ciCke = 1'b1; ciN = 8'd5; ciValueA = 32'd0;
    #1;
    check("ci_other_id", {ciDone, ciResult}, 64'd0);
    @(negedge clock);
    ciStart = 1'b0; ciCke = 1'b0; ciN = 8'd0;

    // Single frame 20x2 at 0x1000 with random consumer stalls
    clear_all();
    ready_mode = 1;
    ci_write(3'd1, 32'h0000_1003);
    ci_write(3'd2, 32'd20);
    ci_write(3'd3, 32'd2);
    ci_read(3'd0, rv, rd);
    check("base_aligned", rv, 32'h0000_1000);
    ci_read(3'd7, rv, rd);
    check("cmd7_reads_zero", rv, 32'd0);
    ci_write(3'd4, 32'd1);
    tick(2);
    wait_idle("single");
    build_expected(32'h1000, 20, 2);
    compare_run("single");
    ci_read(3'd5, rv, rd);
    check("single_status", rv, 32'd0);
    ci_read(3'd6, rv, rd);
    check("single_count", rv, 32'd1);

    // Back-pressure: consumer holds off, FIFO fills to 32 and the bus goes quiet
    clear_all();
    ready_mode = 0;
    ci_write(3'd1, 32'h0000_8000);
    ci_write(3'd2, 32'd16);
    ci_write(3'd3, 32'd3);
    ci_write(3'd4, 32'd1);
    tick(2);
    wait_bursts("bp", 2);
    tick(150);
    req_cycles = 0;
    tick(60);
    check("bp_no_request", req_cycles, 0);
    check("bp_bursts_held", 64'(bq_addr.size()), 64'd2);
    check("bp_head_held", {streamValid, streamData}, {1'b1, mem_word(32'h8000)});
    check("bp_nothing_taken", 64'(got.size()), 64'd0);
    ready_mode = 1;
    wait_idle("bp");
    build_expected(32'h8000, 16, 3);
    compare_run("bp");
    ci_read(3'd6, rv, rd);
    check("bp_count", rv, 32'd2);

    // Bus error in the second burst
    clear_all();
    end_pulses = 0;
    err_burst  = 1;
    err_after  = 2;
    ci_write(3'd1, 32'h0000_2000);
    ci_write(3'd2, 32'd20);
    ci_write(3'd3, 32'd2);
    ci_write(3'd4, 32'd1);
    for (int i = 0; i < 2000; i++) begin
      if (end_pulses > 0) break;
      tick(1);
    end
    tick(6);
    check("err_end_pulses", end_pulses, 1);
    check("err_bursts", 64'(bq_addr.size()), 64'd2);
    check("err_fifo_flushed", streamValid, 1'b0);
    ci_read(3'd5, rv, rd);
    check("err_status_first", rv, 32'd2);
    ci_read(3'd5, rv, rd);
    check("err_status_second", rv, 32'd0);
    ci_read(3'd6, rv, rd);
    check("err_count_unchanged", rv, 32'd2);
    err_burst = -1;

    // Continuous 4x1 at 0x3000, stopped during the third frame
    clear_all();
    ci_write(3'd1, 32'h0000_3000);
    ci_write(3'd2, 32'd4);
    ci_write(3'd3, 32'd1);
    ci_write(3'd4, 32'd2);
    tick(2);
    wait_bursts("cont", 3);
    ci_write(3'd4, 32'd0);
    tick(2);
    wait_idle("cont");
    for (int f = 0; f < 3; f++) build_expected(32'h3000, 4, 1);
    compare_run("cont");
    ci_read(3'd6, rv, rd);
    check("cont_count", rv, 32'd5);

    // Base rewritten mid-frame: only the following frame moves
    clear_all();
    ci_write(3'd1, 32'h0000_4000);
    ci_write(3'd2, 32'd8);
    ci_write(3'd3, 32'd2);
    ci_write(3'd4, 32'd2);
    tick(2);
    wait_bursts("rebase", 1);
    ci_write(3'd1, 32'h0000_5000);
    wait_bursts("rebase", 3);
    ci_write(3'd4, 32'd0);
    tick(2);
    wait_idle("rebase");
    build_expected(32'h4000, 8, 2);
    build_expected(32'h5000, 8, 2);
    compare_run("rebase");
    ci_read(3'd0, rv, rd);
    check("rebase_base", rv, 32'h0000_5000);
    ci_read(3'd6, rv, rd);
    check("rebase_count", rv, 32'd7);

    // Reset in the middle of a burst
    clear_all();
    ci_write(3'd1, 32'h0000_1000);
    ci_write(3'd2, 32'd20);
    ci_write(3'd3, 32'd2);
    ci_write(3'd4, 32'd1);
    tick(2);
    wait_bursts("mid_rst", 1);
    tick(6);
    reset = 1'b1;
    #1;
    check("mid_rst_bus_outs", {requestBus, beginTransactionOut, endTransactionOut, addressDataOut,
          byteEnablesOut, readNotWriteOut, burstSizeOut}, 64'd0);
    check("mid_rst_stream_outs", {streamValid, streamLastInLine, streamLastInFrame, streamData}, 64'd0);
    tick(2);
    reset = 1'b0;
    nb = bq_addr.size();
    end_pulses = 0;
    tick(20);
    check("mid_rst_no_restart", 64'(bq_addr.size()), 64'(nb));
    check("mid_rst_no_end", end_pulses, 0);
    check("mid_rst_fifo_empty", streamValid, 1'b0);
    ci_read(3'd5, rv, rd);
    check("mid_rst_status", rv, 32'd0);
    ci_read(3'd6, rv, rd);
    check("mid_rst_count", rv, 32'd0);
    ci_read(3'd0, rv, rd);
    check("mid_rst_base", rv, 32'd0);

    check("framing_companions", framing_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
